// File: rtl/ring_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ring_slot_scheduler
// Purpose  : Round-robin time-slot scheduler built on a one-hot rotating
//            token ring. The slot holding the token may claim the shared
//            resource. A grant lasts until the request drops or MAX_HOLD
//            cycles have passed. Idle slots are stepped past one per cycle.
// Ports    : clk      - clock, every state update on the rising edge
//            rst      - synchronous reset, active-high
//            en       - run enable; 0 parks the token once a grant finishes
//            req      - per-slot level-sensitive request [N-1:0]
//            gnt      - registered one-hot grant, all-zero when idle [N-1:0]
//            gnt_vld  - registered, high exactly when gnt != 0
//            slot     - index of the current token position [SLOT_W-1:0]
//            token    - one-hot ring state, always 1 << slot [N-1:0]
//            wrap     - one-cycle pulse after the token moves N-1 -> 0
// Options  : RING_SKIP_EN - when defined, a scan with en=1 jumps the token in
//            one edge to the first requesting slot (circular, starting at
//            the current slot) and grants it on that same edge.
// Revision : 1.0 - initial release
// ============================================================================
module ring_slot_scheduler #(
    parameter int N        = 14,
    parameter int SLOT_W   = 4,
    parameter int MAX_HOLD = 8,
    parameter int START    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N-1:0]      req,
    output logic [N-1:0]      gnt,
    output logic              gnt_vld,
    output logic [SLOT_W-1:0] slot,
    output logic [N-1:0]      token,
    output logic              wrap
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    localparam logic [SLOT_W-1:0] c_last        = SLOT_W'(N - 1);
    localparam logic [SLOT_W-1:0] c_start       = SLOT_W'(START);
    localparam logic [N-1:0]      c_start_token = N'(1) << START;
    localparam logic [CNT_W-1:0]  c_max_hold    = CNT_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t            r_state;
    logic [N-1:0]      r_token;
    logic [SLOT_W-1:0] r_slot;
    logic [N-1:0]      r_gnt;
    logic              r_gnt_vld;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wrap;

    state_t            w_state_n;
    logic [N-1:0]      w_token_n;
    logic [SLOT_W-1:0] w_slot_n;
    logic [N-1:0]      w_gnt_n;
    logic              w_gnt_vld_n;
    logic [CNT_W-1:0]  w_cnt_n;
    logic              w_wrap_n;

    // Single-step rotation of the ring and the matching index/wrap values.
    logic [N-1:0]      w_rot_token;
    logic [SLOT_W-1:0] w_rot_slot;
    logic              w_rot_wrap;
    logic              w_req_here;

    assign w_rot_token = {r_token[N-2:0], r_token[N-1]};
    assign w_rot_wrap  = (r_slot == c_last);
    assign w_rot_slot  = w_rot_wrap ? '0 : r_slot + SLOT_W'(1);
    assign w_req_here  = req[r_slot];

`ifdef RING_SKIP_EN
    // Circular first-requester search starting at the token slot itself.
    // The wide index lets slot+offset exceed N before folding back.
    logic              w_hit;
    logic [SLOT_W-1:0] w_hit_slot;
    logic              w_hit_wrap;
    logic [N-1:0]      w_hit_token;
    logic [SLOT_W:0]   w_idx;

    always_comb begin
        w_hit      = 1'b0;
        w_hit_slot = r_slot;
        w_hit_wrap = 1'b0;
        w_idx      = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = {1'b0, r_slot} + (SLOT_W + 1)'(i);
            if (w_idx >= (SLOT_W + 1)'(N)) begin
                w_idx = w_idx - (SLOT_W + 1)'(N);
            end
            if (!w_hit && req[w_idx[SLOT_W-1:0]]) begin
                w_hit      = 1'b1;
                w_hit_slot = w_idx[SLOT_W-1:0];
                // Folding back past N means the jump crossed N-1 -> 0.
                w_hit_wrap = ({1'b0, r_slot} + (SLOT_W + 1)'(i)) >= (SLOT_W + 1)'(N);
            end
        end
        w_hit_token = N'(1) << w_hit_slot;
    end
`endif

    always_comb begin
        w_state_n   = r_state;
        w_token_n   = r_token;
        w_slot_n    = r_slot;
        w_gnt_n     = r_gnt;
        w_gnt_vld_n = r_gnt_vld;
        w_cnt_n     = r_cnt;
        w_wrap_n    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Leaving IDLE never moves the token.
                if (en) begin
                    w_state_n = ST_SCAN;
                end
            end

            ST_SCAN: begin
`ifdef RING_SKIP_EN
                if (en) begin
                    // With no request anywhere the token simply waits.
                    if (w_hit) begin
                        w_token_n   = w_hit_token;
                        w_slot_n    = w_hit_slot;
                        w_wrap_n    = w_hit_wrap;
                        w_gnt_n     = w_hit_token;
                        w_gnt_vld_n = 1'b1;
                        w_cnt_n     = CNT_W'(1);
                        w_state_n   = ST_GRANT;
                    end
                end else if (w_req_here) begin
                    w_gnt_n     = r_token;
                    w_gnt_vld_n = 1'b1;
                    w_cnt_n     = CNT_W'(1);
                    w_state_n   = ST_GRANT;
                end else begin
                    w_state_n = ST_IDLE;
                end
`else
                // A request at the token slot is honoured even with en=0.
                if (w_req_here) begin
                    w_gnt_n     = r_token;
                    w_gnt_vld_n = 1'b1;
                    w_cnt_n     = CNT_W'(1);
                    w_state_n   = ST_GRANT;
                end else if (en) begin
                    w_token_n = w_rot_token;
                    w_slot_n  = w_rot_slot;
                    w_wrap_n  = w_rot_wrap;
                end else begin
                    w_state_n = ST_IDLE;
                end
`endif
            end

            ST_GRANT: begin
                // en is only consulted at release so a grant is never cut.
                if (w_req_here && (r_cnt < c_max_hold)) begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end else begin
                    w_gnt_n     = '0;
                    w_gnt_vld_n = 1'b0;
                    w_cnt_n     = '0;
                    w_token_n   = w_rot_token;
                    w_slot_n    = w_rot_slot;
                    w_wrap_n    = w_rot_wrap;
                    w_state_n   = en ? ST_SCAN : ST_IDLE;
                end
            end

            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_token   <= c_start_token;
            r_slot    <= c_start;
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
            r_cnt     <= '0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_token   <= w_token_n;
            r_slot    <= w_slot_n;
            r_gnt     <= w_gnt_n;
            r_gnt_vld <= w_gnt_vld_n;
            r_cnt     <= w_cnt_n;
            r_wrap    <= w_wrap_n;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_vld = r_gnt_vld;
    assign slot    = r_slot;
    assign token   = r_token;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_ring_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_slot_scheduler
// Purpose  : Self-checking bench for ring_slot_scheduler: a vector table,
//            directed multi-cycle sequences and a randomized run against a
//            slot-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_slot_scheduler;

    localparam int N        = 14;
    localparam int SLOT_W   = 4;
    localparam int MAX_HOLD = 8;
    localparam int START    = 0;

    logic              clk;
    logic              rst;
    logic              en;
    logic [N-1:0]      req;
    logic [N-1:0]      gnt;
    logic              gnt_vld;
    logic [SLOT_W-1:0] slot;
    logic [N-1:0]      token;
    logic              wrap;

    int total = 0;
    int bad   = 0;

    ring_slot_scheduler #(
        .N        (N),
        .SLOT_W   (SLOT_W),
        .MAX_HOLD (MAX_HOLD),
        .START    (START)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .slot    (slot),
        .token   (token),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input string nm);
        int n = 0;
        while (!gnt_vld && n < 200) begin
            tick();
            n++;
        end
        chk(nm, 64'(gnt_vld), 64'd1);
    endtask

    // ---------------- reference model -----------------------------------
    // Tracks the token as an integer position, whether the ring is running,
    // which position (if any) holds the grant, and how long it has held.
    int m_pos;
    bit m_run;
    int m_gslot;
    int m_held;
    bit m_wrap;

    function automatic void m_advance();
        m_wrap = (m_pos == N - 1);
        m_pos  = (m_pos + 1) % N;
    endfunction

    function automatic void m_grant();
        m_gslot = m_pos;
        m_held  = 1;
    endfunction

    function automatic void model_step(input bit r, input bit e, input logic [N-1:0] q);
        if (r) begin
            m_pos = START; m_run = 0; m_gslot = -1; m_held = 0; m_wrap = 0;
            return;
        end
        m_wrap = 0;
        if (m_gslot >= 0) begin
            if (q[m_pos] && m_held < MAX_HOLD) m_held++;
            else begin
                m_gslot = -1;
                m_advance();
                m_run = e;
            end
        end else if (!m_run) begin
            m_run = e;
        end else begin
`ifdef RING_SKIP_EN
            if (e) begin
                for (int k = 0; k < N; k++) begin
                    if (m_gslot < 0 && q[(m_pos + k) % N]) begin
                        m_wrap = (m_pos + k >= N);
                        m_pos  = (m_pos + k) % N;
                        m_grant();
                    end
                end
            end else if (q[m_pos]) m_grant();
            else m_run = 0;
`else
            if (q[m_pos]) m_grant();
            else if (e) m_advance();
            else m_run = 0;
`endif
        end
    endfunction

    typedef struct packed {
        logic              rst;
        logic              en;
        logic [N-1:0]      req;
        logic [SLOT_W-1:0] slot;
        logic [N-1:0]      gnt;
        logic              wrap;
    } vec_t;

    vec_t vt [17];

    initial begin
        logic [N-1:0] etok;
        logic [N-1:0] eg;
        int n;
        rst = 1'b1;
        en  = 1'b0;
        req = '0;

`ifndef RING_SKIP_EN
        // ---------------- vector table: {rst,en,req, slot,gnt,wrap} ----------
        vt[0]  = '{1'b1, 1'b0, 14'h0000, 4'd0, 14'h0000, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 14'h0000, 4'd0, 14'h0000, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 14'h0000, 4'd1, 14'h0000, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 14'h0008, 4'd2, 14'h0000, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 14'h0008, 4'd3, 14'h0000, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 14'h0008, 4'd3, 14'h0008, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 14'h0008, 4'd3, 14'h0008, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 14'h0000, 4'd4, 14'h0000, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 14'h0000, 4'd4, 14'h0000, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 14'h0000, 4'd4, 14'h0000, 1'b0};
        vt[10] = '{1'b0, 1'b1, 14'h0010, 4'd4, 14'h0000, 1'b0};
        vt[11] = '{1'b0, 1'b1, 14'h0010, 4'd4, 14'h0010, 1'b0};
        vt[12] = '{1'b0, 1'b0, 14'h0010, 4'd4, 14'h0010, 1'b0};
        vt[13] = '{1'b0, 1'b0, 14'h0000, 4'd5, 14'h0000, 1'b0};
        vt[14] = '{1'b0, 1'b0, 14'h0000, 4'd5, 14'h0000, 1'b0};
        vt[15] = '{1'b0, 1'b1, 14'h0020, 4'd5, 14'h0000, 1'b0};
        vt[16] = '{1'b0, 1'b0, 14'h0020, 4'd5, 14'h0020, 1'b0};
        for (int i = 0; i < 17; i++) begin
            rst = vt[i].rst;
            en  = vt[i].en;
            req = vt[i].req;
            tick();
            etok = N'(1) << vt[i].slot;
            chk($sformatf("vec%0d", i), 64'({slot, token, gnt, gnt_vld, wrap}),
                64'({vt[i].slot, etok, vt[i].gnt, |vt[i].gnt, vt[i].wrap}));
        end

        // ---------------- free-running scan with wrap pulses --------------
        do_reset();
        en = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            tick();
            chk("t1_slot", 64'(slot), 64'((j - 1) % N));
            chk("t1_wrap", 64'(wrap), 64'(j > 1 && ((j - 1) % N) == 0));
            chk("t1_gnt",  64'(gnt), 64'd0);
        end

        // ---------------- full-length hold and forced release -------------
        do_reset();
        req = 14'h0020;
        en  = 1'b1;
        n = 0;
        while (!gnt_vld && n < 40) begin
            tick();
            n++;
        end
        chk("t2_latency", 64'(n), 64'd7);
        chk("t2_gnt", 64'(gnt), 64'h0020);
        n = 0;
        while (gnt_vld && n < 20) begin
            tick();
            n++;
        end
        chk("t2_hold", 64'(n), 64'(MAX_HOLD));
        chk("t2_slot", 64'(slot), 64'd6);

        // ---------------- early request drop ------------------------------
        do_reset();
        req = 14'h0008;
        en  = 1'b1;
        wait_gnt("t3_wait");
        tick();
        chk("t3_gnt2", 64'(gnt), 64'h0008);
        req = '0;
        tick();
        chk("t3_rel", 64'({gnt, slot}), 64'({14'h0000, 4'd4}));
        tick();
        chk("t3_scan", 64'(slot), 64'd5);

        // ---------------- enable dropped mid-grant -------------------------
        do_reset();
        req = 14'h0080;
        en  = 1'b1;
        wait_gnt("t4_wait");
        en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("t4_hold", 64'(gnt), 64'h0080);
        end
        req = '0;
        tick();
        chk("t4_rel", 64'({gnt, slot}), 64'({14'h0000, 4'd8}));
        tick();
        tick();
        chk("t4_frozen", 64'(slot), 64'd8);
        en = 1'b1;
        tick();
        chk("t4_resume0", 64'(slot), 64'd8);
        tick();
        chk("t4_resume1", 64'(slot), 64'd9);
`else
        // ---------------- skip-ahead jump and wrap -------------------------
        do_reset();
        en  = 1'b1;
        req = 14'h0002;
        tick();
        tick();
        chk("t6_first", 64'({slot, gnt}), 64'({4'd1, 14'h0002}));
        req = '0;
        tick();
        chk("t6_rel", 64'(slot), 64'd2);
        req = 14'h0202;
        tick();
        chk("t6_jump", 64'({slot, gnt, wrap}), 64'({4'd9, 14'h0200, 1'b0}));
        req = 14'h0002;
        tick();
        chk("t6_rel2", 64'({slot, gnt}), 64'({4'd10, 14'h0000}));
        tick();
        chk("t6_wrapjump", 64'({slot, gnt, wrap}), 64'({4'd1, 14'h0002, 1'b1}));
`endif

        // ---------------- reset in the middle of a grant -------------------
        do_reset();
        req = 14'h0004;
        en  = 1'b1;
        wait_gnt("t5_wait");
        tick();
        rst = 1'b1;
        tick();
        chk("t5_rst", 64'({gnt, gnt_vld, slot, token, wrap}),
            64'({14'h0000, 1'b0, 4'd0, 14'h0001, 1'b0}));
        rst = 1'b0;
        req = 14'h0001;
        tick();
        chk("t5_idle", 64'({gnt, slot}), 64'({14'h0000, 4'd0}));
        tick();
        chk("t5_grant", 64'(gnt), 64'h0001);

        // ---------------- randomized run against the model -----------------
        rst = 1'b1;
        en  = 1'b0;
        req = '0;
        model_step(1'b1, 1'b0, '0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
            end
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 299) == 0);
            model_step(rst, en, req);
            tick();
            etok = N'(1) << m_pos;
            eg   = (m_gslot >= 0) ? etok : '0;
            chk("rand", 64'({gnt, gnt_vld, slot, token, wrap}),
                64'({eg, (m_gslot >= 0), SLOT_W'(m_pos), etok, m_wrap}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
